// File: rtl/led_status_arbiter.sv
// led_status_arbiter: per-LED priority arbiter with hold timer and 1/8 PWM; LED_IDLE_HEARTBEAT_EN adds an idle blue heartbeat
module led_status_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int HOLD_CYCLES = 10_000_000,
  parameter int HB_BIT      = 26
) (
  input  logic                 mainclk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [2*NUM_REQ-1:0] req_led,
  input  logic [3*NUM_REQ-1:0] req_color,
  output logic [3:0]           led_busy,
  output logic                 led0_r,
  output logic                 led0_g,
  output logic                 led0_b,
  output logic                 led1_r,
  output logic                 led1_g,
  output logic                 led1_b,
  output logic                 led2_r,
  output logic                 led2_g,
  output logic                 led2_b,
  output logic                 led3_r,
  output logic                 led3_g,
  output logic                 led3_b
);
  localparam int CW = $clog2(HOLD_CYCLES) + 1;
  localparam logic [CW-1:0] LOAD = CW'(HOLD_CYCLES - 1);
  typedef enum logic {IDLE, SHOW} slot_e;
  slot_e st_q [4];
  slot_e st_d [4];
  logic [3:0][2:0] col_q, col_d, led_q, led_d;
  logic [3:0][CW-1:0] cnt_q, cnt_d;
  logic [2:0] pwm_q;
  logic gate, idle_b;
  assign gate = &pwm_q;
`ifdef LED_IDLE_HEARTBEAT_EN
  logic [HB_BIT:0] hb_q;
  always_ff @(posedge mainclk) hb_q <= rst ? '0 : hb_q + 1'b1;
  assign idle_b = hb_q[HB_BIT] & gate;
`else
  logic unused_hb;
  assign unused_hb = HB_BIT > 0;
  assign idle_b = 1'b0;
`endif
  // a higher-index requester aimed at the same LED masks every lower one, so each slot sees at most one accept
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = st_q[req_led[2*i +: 2]] == IDLE;
      for (int j = i + 1; j < NUM_REQ; j++)
        if (req_valid[j] && req_led[2*j +: 2] == req_led[2*i +: 2]) req_ready[i] = 1'b0;
    end
  end
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      st_d[k] = (st_q[k] == SHOW && cnt_q[k] == '0) ? IDLE : st_q[k];
      col_d[k] = col_q[k];
      cnt_d[k] = (st_q[k] == SHOW && cnt_q[k] != '0) ? cnt_q[k] - 1'b1 : cnt_q[k];
      for (int i = 0; i < NUM_REQ; i++)
        if (req_valid[i] && req_ready[i] && req_led[2*i +: 2] == 2'(k)) begin
          st_d[k] = SHOW;
          col_d[k] = req_color[3*i +: 3];
          cnt_d[k] = LOAD;
        end
      led_d[k] = st_q[k] == SHOW ? col_q[k] & {3{gate}} : {2'b00, idle_b};
      led_busy[k] = st_q[k] == SHOW;
    end
  end
  always_ff @(posedge mainclk) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) st_q[k] <= IDLE;
      col_q <= '0;
      cnt_q <= '0;
      led_q <= '0;
      pwm_q <= '0;
    end else begin
      st_q <= st_d;
      col_q <= col_d;
      cnt_q <= cnt_d;
      led_q <= led_d;
      pwm_q <= pwm_q + 1'b1;
    end
  end
  assign {led0_r, led0_g, led0_b} = led_q[0];
  assign {led1_r, led1_g, led1_b} = led_q[1];
  assign {led2_r, led2_g, led2_b} = led_q[2];
  assign {led3_r, led3_g, led3_b} = led_q[3];
endmodule
